// File: rtl/mjpeg_frame_sched.sv
// mjpeg_frame_sched: sequences the MJPEG encoder against the camera frame stream.
//   Holds the encoder in reset during warm-up. Picks frames to encode using
//   decimation and downstream backpressure. Gates pixel DE for whole frames only.
//   Watchdogs each encode and resets the encoder on timeout.
// Ports:
//   i_cam_pclk, rst_n            clock, async active-low reset
//   i_enable, i_skip             scheduling enable, frames skipped between encodes
//   i_cam_vsync, i_cam_de        camera frame start (rising edge), pixel valid
//   i_buf_full                   downstream cannot take a new frame
//   i_mjpeg_down                 encoder frame-complete pulse
//   o_mjpeg_rst_n                encoder reset (registered, active low)
//   o_mjpeg_de                   gated DE (combinational)
//   o_busy                       ARM or ENCODE (registered)
//   o_frame_cnt, o_drop_cnt      completed / dropped frame counters (wrap)
//   o_timeout_err                sticky watchdog flag
//   o_state                      current state (debug)
module mjpeg_frame_sched #(
  parameter int unsigned WARMUP_FRAMES   = 30,
  parameter int unsigned TIMEOUT_FRAMES  = 4,
  parameter int unsigned RST_HOLD_CYCLES = 16,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             i_cam_pclk,
  input  logic             rst_n,
  input  logic             i_enable,
  input  logic [3:0]       i_skip,
  input  logic             i_cam_vsync,
  input  logic             i_cam_de,
  input  logic             i_buf_full,
  input  logic             i_mjpeg_down,
  output logic             o_mjpeg_rst_n,
  output logic             o_mjpeg_de,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_frame_cnt,
  output logic [CNT_W-1:0] o_drop_cnt,
  output logic             o_timeout_err,
  output logic [2:0]       o_state
);

  localparam int unsigned WU_W  = (WARMUP_FRAMES   > 1) ? $clog2(WARMUP_FRAMES)   : 1;
  localparam int unsigned TMO_W = (TIMEOUT_FRAMES  > 1) ? $clog2(TIMEOUT_FRAMES)  : 1;
  localparam int unsigned HLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_WARMUP  = 3'd0,
    S_IDLE    = 3'd1,
    S_ARM     = 3'd2,
    S_ENCODE  = 3'd3,
    S_RECOVER = 3'd4
  } state_t;

  localparam state_t RESET_STATE = (WARMUP_FRAMES == 0) ? S_IDLE : S_WARMUP;

  state_t             state, nxt_state;
  logic               vs_q, de_q;
  logic               gate_en, nxt_gate;
  logic [3:0]         dec, nxt_dec;
  logic [TMO_W-1:0]   tmo, nxt_tmo;
  logic [WU_W-1:0]    wu_cnt, nxt_wu;
  logic [HLD_W-1:0]   hold_cnt, nxt_hold;
  logic [CNT_W-1:0]   nxt_frame, nxt_drop;
  logic               nxt_err;
  logic               vs_pos, de_pos;
  logic               idle_rule;

  assign vs_pos     = i_cam_vsync & ~vs_q;
  assign de_pos     = i_cam_de & ~de_q;
  assign o_mjpeg_de = i_cam_de & gate_en;
  assign o_state    = state;

  // State and datapath registers; gate_en clears asynchronously with rst_n
  always_ff @(posedge i_cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RESET_STATE;
      vs_q          <= 1'b0;
      de_q          <= 1'b0;
      gate_en       <= 1'b0;
      dec           <= '0;
      tmo           <= '0;
      wu_cnt        <= '0;
      hold_cnt      <= '0;
      o_frame_cnt   <= '0;
      o_drop_cnt    <= '0;
      o_timeout_err <= 1'b0;
      o_mjpeg_rst_n <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      state         <= nxt_state;
      vs_q          <= i_cam_vsync;
      de_q          <= i_cam_de;
      gate_en       <= nxt_gate;
      dec           <= nxt_dec;
      tmo           <= nxt_tmo;
      wu_cnt        <= nxt_wu;
      hold_cnt      <= nxt_hold;
      o_frame_cnt   <= nxt_frame;
      o_drop_cnt    <= nxt_drop;
      o_timeout_err <= nxt_err;
      o_mjpeg_rst_n <= (nxt_state != S_WARMUP) && (nxt_state != S_RECOVER);
      o_busy        <= (nxt_state == S_ARM) || (nxt_state == S_ENCODE);
    end
  end

  // Next-state and datapath update
  always_comb begin
    nxt_state = state;
    nxt_gate  = gate_en;
    nxt_dec   = dec;
    nxt_tmo   = tmo;
    nxt_wu    = wu_cnt;
    nxt_hold  = hold_cnt;
    nxt_frame = o_frame_cnt;
    nxt_drop  = o_drop_cnt;
    nxt_err   = o_timeout_err;
    idle_rule = 1'b0;

    case (state)
      S_WARMUP: begin
        nxt_gate = 1'b0;
        if (vs_pos) begin
          if (wu_cnt == WU_W'(WARMUP_FRAMES - 1)) begin
            nxt_state = S_IDLE;
            nxt_wu    = '0;
          end else begin
            nxt_wu = wu_cnt + WU_W'(1);
          end
        end
      end
      S_IDLE: idle_rule = 1'b1;
      S_ARM: begin
        nxt_gate = 1'b1;
        if (de_pos) nxt_state = S_ENCODE;
      end
      S_ENCODE: begin
        if (i_mjpeg_down) begin
          // completion frees the scheduler; a coincident vsync is judged as in IDLE
          nxt_frame = o_frame_cnt + CNT_W'(1);
          nxt_gate  = 1'b0;
          nxt_state = S_IDLE;
          idle_rule = 1'b1;
        end else if (vs_pos) begin
          nxt_gate = 1'b0;
          nxt_drop = o_drop_cnt + CNT_W'(1);
          if (tmo == TMO_W'(TIMEOUT_FRAMES - 1)) begin
            nxt_state = S_RECOVER;
            nxt_err   = 1'b1;
            nxt_hold  = '0;
          end else begin
            nxt_tmo = tmo + TMO_W'(1);
          end
        end
      end
      S_RECOVER: begin
        nxt_gate = 1'b0;
        if (hold_cnt == HLD_W'(RST_HOLD_CYCLES - 1)) begin
          nxt_state = S_IDLE;
          nxt_dec   = '0;
          nxt_hold  = '0;
        end else begin
          nxt_hold = hold_cnt + HLD_W'(1);
        end
      end
      default: nxt_state = RESET_STATE;
    endcase

    // Frame selection at frame start
    if (idle_rule && vs_pos) begin
      if (dec != 4'd0) begin
        nxt_dec = dec - 4'd1;
      end else if (i_buf_full) begin
        nxt_drop = o_drop_cnt + CNT_W'(1);
      end else if (i_enable) begin
        nxt_dec   = i_skip;
        nxt_gate  = 1'b1;
        nxt_tmo   = '0;
        nxt_state = S_ARM;
      end
    end
  end

endmodule

// File: tb/tb_mjpeg_frame_sched.sv
// Directed bench for mjpeg_frame_sched: frame-level vector table plus
// hand sequences for warm-up, coincident done/vsync, watchdog and async reset.
module tb_mjpeg_frame_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, vsync, de, buf_full, down;
  logic [3:0]  skip;
  logic        mjpeg_rst_n, mjpeg_de, busy, timeout_err;
  logic [15:0] frame_cnt, drop_cnt;
  logic [2:0]  state;

  int errors = 0;
  int checks = 0;

  localparam logic [2:0] ST_WARMUP  = 3'd0;
  localparam logic [2:0] ST_IDLE    = 3'd1;
  localparam logic [2:0] ST_ARM     = 3'd2;
  localparam logic [2:0] ST_ENCODE  = 3'd3;
  localparam logic [2:0] ST_RECOVER = 3'd4;

  mjpeg_frame_sched #(
    .WARMUP_FRAMES(3), .TIMEOUT_FRAMES(4), .RST_HOLD_CYCLES(16), .CNT_W(16)
  ) dut (
    .i_cam_pclk(clk), .rst_n(rst_n), .i_enable(enable), .i_skip(skip),
    .i_cam_vsync(vsync), .i_cam_de(de), .i_buf_full(buf_full),
    .i_mjpeg_down(down), .o_mjpeg_rst_n(mjpeg_rst_n), .o_mjpeg_de(mjpeg_de),
    .o_busy(busy), .o_frame_cnt(frame_cnt), .o_drop_cnt(drop_cnt),
    .o_timeout_err(timeout_err), .o_state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        buf_full;
    logic        enable;
    logic [3:0]  skip;
    logic        send_de;
    logic        send_done;
    logic [2:0]  exp_state;
    logic [15:0] exp_frame;
    logic [15:0] exp_drop;
    logic        exp_busy;
    logic        exp_pass;
  } vec_t;

  vec_t vecs[14];

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1;
    cyc(1);
    vsync = 1'b0;
    cyc(1);
  endtask

  // One camera frame: vsync, a burst of 4 DE pulses, optional encoder done
  task automatic run_frame(input vec_t r, output int passed);
    passed   = 0;
    buf_full = r.buf_full;
    enable   = r.enable;
    skip     = r.skip;
    pulse_vsync();
    cyc(1);
    if (r.send_de) begin
      for (int i = 0; i < 4; i++) begin
        de = 1'b1;
        #1;
        if (mjpeg_de) passed++;
        cyc(1);
        de = 1'b0;
        cyc(1);
      end
    end
    if (r.send_done) begin
      down = 1'b1;
      cyc(1);
      down = 1'b0;
    end
    cyc(2);
  endtask

  initial begin
    int passed;
    int exp_drop;
    rst_n = 1'b0; enable = 1'b1; vsync = 1'b0; de = 1'b0;
    buf_full = 1'b0; down = 1'b0; skip = 4'd0;

    //                buf en  skip  de   dn   state     frame   drop  busy pass
    vecs[0]  = '{1'b0,1'b1,4'd2,1'b1,1'b1,ST_IDLE,  16'd1,16'd0,1'b0,1'b1};
    vecs[1]  = '{1'b0,1'b1,4'd2,1'b1,1'b1,ST_IDLE,  16'd1,16'd0,1'b0,1'b0};
    vecs[2]  = '{1'b0,1'b1,4'd2,1'b1,1'b1,ST_IDLE,  16'd1,16'd0,1'b0,1'b0};
    vecs[3]  = '{1'b0,1'b1,4'd2,1'b1,1'b1,ST_IDLE,  16'd2,16'd0,1'b0,1'b1};
    vecs[4]  = '{1'b0,1'b1,4'd2,1'b1,1'b1,ST_IDLE,  16'd2,16'd0,1'b0,1'b0};
    vecs[5]  = '{1'b0,1'b1,4'd2,1'b1,1'b1,ST_IDLE,  16'd2,16'd0,1'b0,1'b0};
    vecs[6]  = '{1'b0,1'b1,4'd2,1'b1,1'b1,ST_IDLE,  16'd3,16'd0,1'b0,1'b1};
    vecs[7]  = '{1'b0,1'b1,4'd2,1'b1,1'b1,ST_IDLE,  16'd3,16'd0,1'b0,1'b0};
    vecs[8]  = '{1'b0,1'b1,4'd2,1'b1,1'b1,ST_IDLE,  16'd3,16'd0,1'b0,1'b0};
    vecs[9]  = '{1'b1,1'b1,4'd0,1'b1,1'b0,ST_IDLE,  16'd3,16'd1,1'b0,1'b0};
    vecs[10] = '{1'b1,1'b1,4'd0,1'b1,1'b0,ST_IDLE,  16'd3,16'd2,1'b0,1'b0};
    vecs[11] = '{1'b0,1'b1,4'd0,1'b1,1'b1,ST_IDLE,  16'd4,16'd2,1'b0,1'b1};
    vecs[12] = '{1'b0,1'b0,4'd0,1'b1,1'b0,ST_IDLE,  16'd4,16'd2,1'b0,1'b0};
    vecs[13] = '{1'b0,1'b1,4'd0,1'b1,1'b0,ST_ENCODE,16'd4,16'd2,1'b1,1'b1};

    // Reset values
    cyc(3);
    check("rst_state", 32'(state), 32'(ST_WARMUP));
    check("rst_enc_rstn", 32'(mjpeg_rst_n), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame", 32'(frame_cnt), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_err", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;
    cyc(2);

    // Warm-up: encoder reset low through 3 vsync edges, DE blocked
    for (int k = 0; k < 3; k++) begin
      de = 1'b1;
      #1;
      check("wu_de_gated", 32'(mjpeg_de), 32'd0);
      de = 1'b0;
      cyc(1);
      vsync = 1'b1;
      #1;
      check("wu_rstn_before_edge", 32'(mjpeg_rst_n), 32'd0);
      check("wu_state_before_edge", 32'(state), 32'(ST_WARMUP));
      cyc(1);
      vsync = 1'b0;
      check("wu_rstn_after_edge", 32'(mjpeg_rst_n), (k == 2) ? 32'd1 : 32'd0);
      cyc(2);
    end
    check("wu_done_state", 32'(state), 32'(ST_IDLE));

    // Frame table: decimation, backpressure, enable
    for (int i = 0; i < 14; i++) begin
      run_frame(vecs[i], passed);
      check($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
      check($sformatf("v%0d_frame", i), 32'(frame_cnt), 32'(vecs[i].exp_frame));
      check($sformatf("v%0d_drop", i), 32'(drop_cnt), 32'(vecs[i].exp_drop));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      check($sformatf("v%0d_pass", i), 32'(passed), vecs[i].exp_pass ? 32'd4 : 32'd0);
    end
    exp_drop = 2;

    // Enable falling mid-encode does not abort the frame
    enable = 1'b0;
    cyc(2);
    down = 1'b1;
    cyc(1);
    down = 1'b0;
    check("en_fall_state", 32'(state), 32'(ST_IDLE));
    check("en_fall_frame", 32'(frame_cnt), 32'd5);
    enable = 1'b1;
    cyc(2);

    // Done coincident with vsync: count and re-arm in the same cycle
    run_frame(vecs[13], passed);
    check("co_pre_state", 32'(state), 32'(ST_ENCODE));
    vsync = 1'b1;
    down  = 1'b1;
    cyc(1);
    vsync = 1'b0;
    down  = 1'b0;
    check("co_frame", 32'(frame_cnt), 32'd6);
    check("co_state", 32'(state), 32'(ST_ARM));
    check("co_busy", 32'(busy), 32'd1);
    de = 1'b1;
    #1;
    check("co_de_pass", 32'(mjpeg_de), 32'd1);
    cyc(1);
    de = 1'b0;
    down = 1'b1;
    cyc(1);
    down = 1'b0;
    check("co_next_frame", 32'(frame_cnt), 32'd7);
    check("co_drop", 32'(drop_cnt), 32'(exp_drop));
    cyc(2);

    // Watchdog: 4 vsyncs without done -> RECOVER for 16 cycles
    run_frame(vecs[13], passed);
    check("wd_pre_state", 32'(state), 32'(ST_ENCODE));
    for (int k = 0; k < 3; k++) begin
      pulse_vsync();
      exp_drop++;
      check("wd_state_enc", 32'(state), 32'(ST_ENCODE));
      check("wd_drop", 32'(drop_cnt), 32'(exp_drop));
      de = 1'b1;
      #1;
      check("wd_de_closed", 32'(mjpeg_de), 32'd0);
      de = 1'b0;
      check("wd_err_clear", 32'(timeout_err), 32'd0);
    end
    vsync = 1'b1;
    cyc(1);
    vsync = 1'b0;
    exp_drop++;
    check("wd_state_rec", 32'(state), 32'(ST_RECOVER));
    check("wd_err_set", 32'(timeout_err), 32'd1);
    check("wd_drop4", 32'(drop_cnt), 32'(exp_drop));
    check("wd_rstn_low0", 32'(mjpeg_rst_n), 32'd0);
    for (int k = 1; k < 16; k++) begin
      cyc(1);
      check($sformatf("wd_rstn_low%0d", k), 32'(mjpeg_rst_n), 32'd0);
    end
    cyc(1);
    check("wd_rstn_high", 32'(mjpeg_rst_n), 32'd1);
    check("wd_state_idle", 32'(state), 32'(ST_IDLE));
    check("wd_err_sticky", 32'(timeout_err), 32'd1);
    cyc(2);

    // Async reset mid-encode with DE high
    run_frame(vecs[13], passed);
    check("ar_pass", 32'(passed), 32'd4);
    de = 1'b1;
    #1;
    check("ar_de_open", 32'(mjpeg_de), 32'd1);
    rst_n = 1'b0;
    #1;
    check("ar_de_closed", 32'(mjpeg_de), 32'd0);
    check("ar_state", 32'(state), 32'(ST_WARMUP));
    check("ar_rstn", 32'(mjpeg_rst_n), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_frame", 32'(frame_cnt), 32'd0);
    check("ar_drop", 32'(drop_cnt), 32'd0);
    check("ar_err", 32'(timeout_err), 32'd0);
    de = 1'b0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
